// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryptor, one round per clock with on-the-fly key expansion
module aes128_encrypt_iter #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused: row r of column c comes from column (c+r) mod 4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      y[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      y[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      y[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      y[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return y;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] next_rkey, sr_sb;

  assign next_rkey = key_step(rkey_q, rcon(round_q));
  assign sr_sb     = sub_shift(state_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      round_q     <= '0;
      state_q     <= '0;
      rkey_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_q     <= state_d;
      rkey_q      <= rkey_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_d     = state_q;
    rkey_d      = rkey_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_data ^ in_key;
          rkey_d  = in_key;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy   = 1'b1;
        rkey_d = next_rkey;
        // Final round skips MixColumns and lands directly in the output register.
        if (round_q == LAST_ROUND) begin
          out_data_d  = sr_sb ^ next_rkey;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end else begin
          state_d = mix_columns(sr_sb) ^ next_rkey;
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - randomized self-checking bench for aes128_encrypt_iter against a FIPS-197 model
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  aes128_encrypt_iter #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_sent = 0;
  int n_acc  = 0;

  logic [7:0] sb [256];
  logic [7:0] isb[256];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] r1;
  } job_t;
  job_t jobq[$];
  int   acc_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv, r, s;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s ^= r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] bt(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] rk(input logic [127:0] key, input int n);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] sub_f(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv ? isb[bt(x, i)] : sb[bt(x, i)];
    return y;
  endfunction

  function automatic logic [127:0] shift_f(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(r+4*c) -: 8] = bt(x, r + 4*(inv ? (c - r + 4) % 4 : (c + r) % 4));
    return y;
  endfunction

  function automatic logic [127:0] mix_f(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0]   cf[4];
    logic [7:0]   acc;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(cf[(k - r + 4) % 4], bt(x, k + 4*c));
        y[127-8*(r+4*c) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic void aes_enc(input logic [127:0] pt, input logic [127:0] key,
                                  output logic [127:0] ct, output logic [127:0] r1);
    logic [127:0] s;
    s  = pt ^ rk(key, 0);
    r1 = '0;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      s = shift_f(sub_f(s, 1'b0), 1'b0);
      if (rnd < 10) s = mix_f(s, 1'b0);
      s ^= rk(key, rnd);
      if (rnd == 1) r1 = s;
    end
    ct = s;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s;
    s = ct ^ rk(key, 10);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      s = sub_f(shift_f(s, 1'b1), 1'b1) ^ rk(key, rnd);
      if (rnd > 0) s = mix_f(s, 1'b1);
    end
    return s;
  endfunction

  // Cycle-level expectation: 0 idle, 1 computing (cnt rounds done), 2 holding result.
  initial begin : compare
    int           mode;
    int           cnt;
    int           cyc;
    logic [127:0] exp_out;
    job_t         j;
    mode = 0; cnt = 0; cyc = 0; exp_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        mode = 0; cnt = 0; exp_out = '0;
        jobq.delete();
      end else begin
        chk("in_ready", 128'(in_ready), 128'(mode == 0));
        chk("busy", 128'(busy), 128'(mode == 1));
        chk("out_valid", 128'(out_valid), 128'(mode == 2));
        chk("out_data", out_data, exp_out);
        if (mode == 1 && cnt == 1) chk("round1_state", dut.state_q, jobq[0].r1);
        case (mode)
          0: if (in_valid) begin
            j.pt  = in_data;
            j.key = in_key;
            aes_enc(j.pt, j.key, j.ct, j.r1);
            jobq.push_back(j);
            acc_q.push_back(cyc);
            n_acc++;
            mode = 1;
            cnt  = 0;
          end
          1: begin
            cnt++;
            if (cnt == 10) begin
              mode    = 2;
              exp_out = jobq[0].ct;
            end
          end
          default: if (out_ready) begin
            chk("decrypt_roundtrip", aes_dec(out_data, jobq[0].key), jobq[0].pt);
            void'(jobq.pop_front());
            mode = 0;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key, input bit hold_valid);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
    end
    tick();
    n_sent++;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_out(input int hold, output logic [127:0] res);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: out_valid low for %0d cycles, required high", n);
    end
    res = out_data;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
  endtask

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] ct, r1, res;
    int           n, hold;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    aes_enc(C1_PT, C1_KEY, ct, r1);
    chk("model_c1", ct, C1_CT);
    aes_enc(B_PT, B_KEY, ct, r1);
    chk("model_b_ct", ct, B_CT);
    chk("model_b_r1", r1, B_R1);
    aes_enc('0, '0, ct, r1);
    chk("model_zero", ct, Z_CT);

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_data", out_data, 128'd0);

    out_ready = 1'b1;
    send(C1_PT, C1_KEY, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'd10);
    chk("c1_ct", out_data, C1_CT);
    tick();

    send(B_PT, B_KEY, 1'b0);
    wait_out(0, res);
    chk("b_ct", res, B_CT);

    send('0, '0, 1'b0);
    wait_out(0, res);
    chk("zero_ct", res, Z_CT);

    acc_q.delete();
    for (int k = 0; k < 3; k++)
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    in_valid = 1'b0;
    wait_out(0, res);
    chk("b2b_gap1", 128'(acc_q[1] - acc_q[0]), 128'd12);
    chk("b2b_gap2", 128'(acc_q[2] - acc_q[1]), 128'd12);

    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_out(20, res);

    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    wait_out(0, res);

    send(C1_PT, C1_KEY, 1'b0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_data", out_data, 128'd0);
    send(C1_PT, C1_KEY, 1'b0);
    wait_out(0, res);
    chk("c1_after_reset", res, C1_CT);

    for (int k = 0; k < 6; k++) begin
      hold      = int'($urandom_range(0, 3));
      out_ready = (hold == 0);
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      wait_out(hold, res);
    end

    repeat (3) tick();
    chk("accept_count", 128'(n_acc), 128'(n_sent));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
